lct_ghost_filter: RTL and testbench
===================================

LCT_GHOST_FILTER -- requirements
Module: lct_ghost_filter

Interface
REQ-001 Parameter: KEY_W, 7, key wire-group field width.
REQ-002 Parameter: DT_W, 3, deadtime counter width.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 bw1, bq1, fa1, bv1  in  KEY_W, 2, 1, 1  best track from promoter: key, quality, accelerator flag, valid.
REQ-006 bw2, bq2, fa2, bv2  in  KEY_W, 2, 1, 1  second-best track, same fields.
REQ-007 en  in  1  filter enable; low = pass-through.
REQ-008 dt  in  DT_W  deadtime in BX; quasi-static.
REQ-009 lw1, lq1, la1, lv1  out  KEY_W, 2, 1, 1  first surviving track.
REQ-010 lw2, lq2, la2, lv2  out  KEY_W, 2, 1, 1  second surviving track.
REQ-011 sup_cnt  out  8  saturating count of suppressed tracks.

Function
REQ-012 Two history slots S0, S1 shall hold key, quality, counter cnt (DT_W bits); slot busy iff cnt != 0.
REQ-013 Track k (1 or 2) shall be suppressed iff bvk=1, en=1, and some busy slot has |key - bwk| <= 1 and slot quality >= bqk.
REQ-014 Key distance shall be unsigned, no wrap: keys 0 and 2^KEY_W-1 are not adjacent.
REQ-015 Input tracks with bvk=0 are ignored (never accepted or suppressed); their other fields are don't-care.
REQ-016 Outputs shall be registered, latency exactly 1 clk: inputs of cycle N appear after edge N.
REQ-017 Output 1 shall carry track 1 if accepted, else track 2 if accepted, else zeros with lv1=0.
REQ-018 Output 2 shall carry track 2 only when both tracks accepted; otherwise all fields 0.
REQ-019 Output fields of an invalid output slot shall be 0 (lw, lq, la, lv).
REQ-020 Slot decisions shall use slot state before the edge; slot update and outputs occur on the same edge.
REQ-021 Both accepted: S0 <= track 1, S1 <= track 2, both cnt <= dt.
REQ-022 One accepted: load into the busy slot within +/-1 key (S0 if both), else a non-busy slot (S0 first), else slot with lower cnt (tie S0); cnt <= dt.
REQ-023 Slots not loaded in a cycle shall decrement cnt by 1 if nonzero, hold at 0 otherwise.
REQ-024 dt=0: slots shall never become busy; every valid track accepted.
REQ-025 Suppression window: accepted track at cycle N blocks matching tracks in cycles N+1..N+dt inclusive; cycle N+dt+1 not blocked.
REQ-026 Tracks 1 and 2 in the same cycle shall never suppress each other.
REQ-027 sup_cnt shall add number of suppressed tracks per cycle (0, 1, 2), saturating at 255.
REQ-028 en=0: tracks pass unchanged at 1-clk latency, all slot cnt <= 0, sup_cnt held.
REQ-029 Accelerator flag shall not affect matching; it is carried through only.

Reset
REQ-030 rst_n low shall immediately clear all outputs to 0, all slot fields to 0, sup_cnt to 0.
REQ-031 After rst_n deassertion the first sampling edge shall behave as a normal cycle with empty history.
REQ-032 Reset asserted mid-deadtime shall abort the window; no suppression after release.

Verification
REQ-033 dt=3, en=1; bw1=40,bq1=2,bv1=1 at N, repeat at N+1..N+4 -> output valid after N and N+4 only; sup_cnt=3.
REQ-034 dt=2; track key 40 q=1 at N, key 41 q=3 at N+1 -> both output (higher quality passes); slot now key 41 q=3.
REQ-035 dt=4; key 0 q=3 at N, key 127 q=0 at N+1 -> N+1 track passes (no wrap adjacency).
REQ-036 dt=2; keys 10 and 11 both valid at N -> lv1=lv2=1 after N; at N+1 track1 key 10 q=0 suppressed, track2 key 90 valid -> lw1=90, lv2=0.
REQ-037 en=0 with 300 identical tracks -> all pass, sup_cnt unchanged; then 300 suppressions with en=1 -> sup_cnt=255.
REQ-038 dt=7, accept key 50, assert rst_n low at N+2, release -> outputs zero during reset; key 50 at N+5 passes.

Source files
------------

// File: rtl/lct_ghost_filter_if.sv
// Track bus between the LCT promoter and the ghost filter: two candidate
// tracks plus filter control going in, two surviving tracks and the
// suppression counter coming out.
interface lct_ghost_filter_if #(
    parameter int KEY_W = 7,
    parameter int DT_W  = 3
);
    logic [KEY_W-1:0] bw1, bw2;
    logic [1:0]       bq1, bq2;
    logic             fa1, fa2;
    logic             bv1, bv2;
    logic             en;
    logic [DT_W-1:0]  dt;

    logic [KEY_W-1:0] lw1, lw2;
    logic [1:0]       lq1, lq2;
    logic             la1, la2;
    logic             lv1, lv2;
    logic [7:0]       sup_cnt;

    modport master (
        output bw1, bq1, fa1, bv1, bw2, bq2, fa2, bv2, en, dt,
        input  lw1, lq1, la1, lv1, lw2, lq2, la2, lv2, sup_cnt
    );

    modport slave (
        input  bw1, bq1, fa1, bv1, bw2, bq2, fa2, bv2, en, dt,
        output lw1, lq1, la1, lv1, lw2, lq2, la2, lv2, sup_cnt
    );
endinterface

// File: rtl/lct_ghost_filter.sv
// Ghost filter for LCT track pairs: a track that lands within one wire
// group of a recently accepted track of equal or better quality, inside
// the deadtime window, is dropped. Surviving tracks are packed towards
// output 1 and registered with one clock of latency.
module lct_ghost_filter #(
    parameter int KEY_W = 7,
    parameter int DT_W  = 3
) (
    input logic               clk,
    input logic               rst_n,
    lct_ghost_filter_if.slave bus
);

    // Unsigned key distance <= 1, evaluated one bit wider so the extreme
    // keys never wrap into adjacency.
    function automatic logic near(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        logic [KEY_W:0] ae;
        logic [KEY_W:0] be;
        ae = {1'b0, a};
        be = {1'b0, b};
        return (ae == be) || (ae + 1'b1 == be) || (be + 1'b1 == ae);
    endfunction

    logic [1:0][KEY_W-1:0] s_key, n_key;
    logic [1:0][1:0]       s_q,   n_q;
    logic [1:0][DT_W-1:0]  s_cnt, n_cnt;
    logic [1:0]            busy, near1, near2, hit1, hit2, near_sel;
    logic                  sup1, sup2, acc1, acc2, idx;
    logic [KEY_W-1:0]      sel_key;
    logic [1:0]            sel_q;

    logic [KEY_W-1:0] o_w1, o_w2, n_w1, n_w2;
    logic [1:0]       o_q1, o_q2, n_q1, n_q2;
    logic             o_a1, o_a2, n_a1, n_a2;
    logic             o_v1, o_v2, n_v1, n_v2;
    logic [7:0]       sup_r, n_sup;
    logic [8:0]       sup_sum;

    // Match both candidate tracks against the history, choose survivors,
    // and work out the next slot contents and counter value.
    always_comb begin
        n_key    = s_key;
        n_q      = s_q;
        n_cnt    = '0;
        busy     = '0;
        near1    = '0;
        near2    = '0;
        hit1     = '0;
        hit2     = '0;
        idx      = 1'b0;
        sel_key  = '0;
        sel_q    = '0;
        near_sel = '0;

        for (int unsigned i = 0; i < 2; i++) begin
            busy[i]  = (s_cnt[i] != '0);
            near1[i] = busy[i] && near(s_key[i], bus.bw1);
            near2[i] = busy[i] && near(s_key[i], bus.bw2);
            hit1[i]  = near1[i] && (s_q[i] >= bus.bq1);
            hit2[i]  = near2[i] && (s_q[i] >= bus.bq2);
            n_cnt[i] = busy[i] ? s_cnt[i] - 1'b1 : '0;
        end

        sup1 = bus.bv1 && bus.en && (|hit1);
        sup2 = bus.bv2 && bus.en && (|hit2);
        acc1 = bus.bv1 && !sup1;
        acc2 = bus.bv2 && !sup2;

        if (!bus.en) begin
            n_cnt = '0;
        end else if (acc1 && acc2) begin
            n_key[0] = bus.bw1;  n_q[0] = bus.bq1;  n_cnt[0] = bus.dt;
            n_key[1] = bus.bw2;  n_q[1] = bus.bq2;  n_cnt[1] = bus.dt;
        end else if (acc1 || acc2) begin
            sel_key  = acc1 ? bus.bw1 : bus.bw2;
            sel_q    = acc1 ? bus.bq1 : bus.bq2;
            near_sel = acc1 ? near1 : near2;
            // Prefer refreshing a neighbouring slot, then a free slot,
            // then evict whichever slot is closer to expiring.
            if (near_sel[0])      idx = 1'b0;
            else if (near_sel[1]) idx = 1'b1;
            else if (!busy[0])    idx = 1'b0;
            else if (!busy[1])    idx = 1'b1;
            else                  idx = (s_cnt[1] < s_cnt[0]);
            n_key[idx] = sel_key;
            n_q[idx]   = sel_q;
            n_cnt[idx] = bus.dt;
        end

        n_w1 = '0; n_q1 = '0; n_a1 = 1'b0; n_v1 = 1'b0;
        n_w2 = '0; n_q2 = '0; n_a2 = 1'b0; n_v2 = 1'b0;
        if (acc1) begin
            n_w1 = bus.bw1; n_q1 = bus.bq1; n_a1 = bus.fa1; n_v1 = 1'b1;
            if (acc2) begin
                n_w2 = bus.bw2; n_q2 = bus.bq2; n_a2 = bus.fa2; n_v2 = 1'b1;
            end
        end else if (acc2) begin
            n_w1 = bus.bw2; n_q1 = bus.bq2; n_a1 = bus.fa2; n_v1 = 1'b1;
        end

        sup_sum = {1'b0, sup_r} + {8'd0, sup1} + {8'd0, sup2};
        n_sup   = sup_sum[8] ? 8'hFF : sup_sum[7:0];
    end

    // History slots, registered outputs and suppression counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_key <= '0; s_q <= '0; s_cnt <= '0;
            o_w1 <= '0; o_q1 <= '0; o_a1 <= 1'b0; o_v1 <= 1'b0;
            o_w2 <= '0; o_q2 <= '0; o_a2 <= 1'b0; o_v2 <= 1'b0;
            sup_r <= '0;
        end else begin
            s_key <= n_key; s_q <= n_q; s_cnt <= n_cnt;
            o_w1 <= n_w1; o_q1 <= n_q1; o_a1 <= n_a1; o_v1 <= n_v1;
            o_w2 <= n_w2; o_q2 <= n_q2; o_a2 <= n_a2; o_v2 <= n_v2;
            sup_r <= n_sup;
        end
    end

    assign bus.lw1 = o_w1;
    assign bus.lq1 = o_q1;
    assign bus.la1 = o_a1;
    assign bus.lv1 = o_v1;
    assign bus.lw2 = o_w2;
    assign bus.lq2 = o_q2;
    assign bus.la2 = o_a2;
    assign bus.lv2 = o_v2;
    assign bus.sup_cnt = sup_r;

endmodule

// File: tb/tb_lct_ghost_filter.sv
// Directed bench for lct_ghost_filter: hand-computed expectations for
// deadtime windows, quality override, key edges, pair handling,
// pass-through, counter saturation and mid-window reset.
module tb_lct_ghost_filter;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    lct_ghost_filter_if #(.KEY_W(7), .DT_W(3)) bus ();

    lct_ghost_filter #(.KEY_W(7), .DT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input logic v, input int w, input int q, input logic a);
        bus.bv1 = v; bus.bw1 = 7'(w); bus.bq1 = 2'(q); bus.fa1 = a;
    endtask

    task automatic set2(input logic v, input int w, input int q, input logic a);
        bus.bv2 = v; bus.bw2 = 7'(w); bus.bq2 = 2'(q); bus.fa2 = a;
    endtask

    task automatic idle(input int n);
        set1(0, 0, 0, 0);
        set2(0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_o1(input string tag, input logic v, input int w, input int q, input logic a);
        chk({tag, ".lv1"}, 32'(bus.lv1), 32'(v));
        chk({tag, ".lw1"}, 32'(bus.lw1), 32'(w));
        chk({tag, ".lq1"}, 32'(bus.lq1), 32'(q));
        chk({tag, ".la1"}, 32'(bus.la1), 32'(a));
    endtask

    task automatic chk_o2(input string tag, input logic v, input int w, input int q, input logic a);
        chk({tag, ".lv2"}, 32'(bus.lv2), 32'(v));
        chk({tag, ".lw2"}, 32'(bus.lw2), 32'(w));
        chk({tag, ".lq2"}, 32'(bus.lq2), 32'(q));
        chk({tag, ".la2"}, 32'(bus.la2), 32'(a));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        bus.en   = 1'b1;
        bus.dt   = 3'd3;
        set1(0, 0, 0, 0);
        set2(0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_o1("rst", 0, 0, 0, 0);
        chk_o2("rst", 0, 0, 0, 0);
        chk("rst.sup", 32'(bus.sup_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Deadtime 3: accept, three suppressions, accept again.
        bus.dt = 3'd3;
        set1(1, 40, 2, 1);
        tick(); chk_o1("dt3.n0", 1, 40, 2, 1); chk_o2("dt3.n0", 0, 0, 0, 0);
        set1(1, 40, 2, 0);
        tick(); chk_o1("dt3.n1", 0, 0, 0, 0);
        tick(); chk_o1("dt3.n2", 0, 0, 0, 0);
        tick(); chk_o1("dt3.n3", 0, 0, 0, 0);
        tick(); chk_o1("dt3.n4", 1, 40, 2, 0);
        chk("dt3.sup", 32'(bus.sup_cnt), 3);
        idle(4);

        // Higher quality neighbour passes and takes over the slot.
        bus.dt = 3'd2;
        set1(1, 40, 1, 0);
        tick(); chk_o1("q.n0", 1, 40, 1, 0);
        set1(1, 41, 3, 0);
        tick(); chk_o1("q.n1", 1, 41, 3, 0);
        set1(1, 40, 3, 0);
        tick(); chk_o1("q.n2", 0, 0, 0, 0);
        chk("q.sup", 32'(bus.sup_cnt), 4);
        idle(3);

        // Keys 0 and 127 are not neighbours; 0 and 1 are.
        bus.dt = 3'd4;
        set1(1, 0, 3, 0);
        tick(); chk_o1("edge.n0", 1, 0, 3, 0);
        set1(1, 127, 0, 0);
        tick(); chk_o1("edge.n1", 1, 127, 0, 0);
        set1(1, 1, 0, 0);
        tick(); chk_o1("edge.n2", 0, 0, 0, 0);
        chk("edge.sup", 32'(bus.sup_cnt), 5);
        idle(5);

        // Pair in one cycle, then track 2 promoted to output 1.
        bus.dt = 3'd2;
        set1(1, 10, 3, 0);
        set2(1, 11, 3, 1);
        tick(); chk_o1("pair.n0", 1, 10, 3, 0); chk_o2("pair.n0", 1, 11, 3, 1);
        set1(1, 10, 0, 0);
        set2(1, 90, 1, 1);
        tick(); chk_o1("pair.n1", 1, 90, 1, 1); chk_o2("pair.n1", 0, 0, 0, 0);
        chk("pair.sup", 32'(bus.sup_cnt), 6);
        idle(3);

        // Zero deadtime never builds history.
        bus.dt = 3'd0;
        set1(1, 20, 3, 0);
        set2(0, 0, 0, 0);
        tick(); chk_o1("dt0.n0", 1, 20, 3, 0);
        tick(); chk_o1("dt0.n1", 1, 20, 3, 0);
        tick(); chk_o1("dt0.n2", 1, 20, 3, 0);
        chk("dt0.sup", 32'(bus.sup_cnt), 6);

        // Pass-through, then saturation of the suppression counter.
        bus.dt = 3'd7;
        bus.en = 1'b0;
        set1(1, 40, 3, 0);
        set2(1, 40, 3, 0);
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("off.lv1", 32'(bus.lv1), 1);
            chk("off.lv2", 32'(bus.lv2), 1);
        end
        chk("off.sup", 32'(bus.sup_cnt), 6);
        bus.en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 0)   chk("sat.first.lv2", 32'(bus.lv2), 1);
            if (i == 1)   chk("sat.blocked.lv1", 32'(bus.lv1), 0);
            if (i == 7)   chk("sat.sup8", 32'(bus.sup_cnt), 20);
            if (i == 141) chk("sat.sup254", 32'(bus.sup_cnt), 254);
            if (i == 142) chk("sat.sup255", 32'(bus.sup_cnt), 255);
        end
        chk("sat.end", 32'(bus.sup_cnt), 255);
        idle(8);

        // Reset in the middle of a deadtime window.
        set1(1, 50, 2, 0);
        tick(); chk_o1("rw.n0", 1, 50, 2, 0);
        set1(1, 60, 1, 0);
        tick(); chk_o1("rw.n1", 1, 60, 1, 0);
        set1(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_o1("rw.async", 0, 0, 0, 0);
        chk("rw.sup", 32'(bus.sup_cnt), 0);
        tick(); chk_o1("rw.n2", 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick(); chk_o1("rw.n4", 0, 0, 0, 0);
        set1(1, 50, 0, 0);
        tick(); chk_o1("rw.n5", 1, 50, 0, 0);
        chk("rw.sup5", 32'(bus.sup_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
